cover_toggle_sched: RTL
=======================

COVER_TOGGLE_SCHED -- requirements
Module: cover_toggle_sched

Interface
REQ-001 Parameter: W, default 21, width of the toggle hit vector.
REQ-002 Parameter: COVER_INDEX, default 0, global cover index of bit 0.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  reset is synchronous and active-high.
REQ-005 Port: valid  input  W  per-point toggle hit strobes, sampled each cycle.
REQ-006 Port: enable  input  1  when low, hits on valid are ignored.
REQ-007 Port: clear  input  1  synchronous, restarts the coverage session.
REQ-008 Port: out_valid  output  1  a report record is presented.
REQ-009 Port: out_ready  input  1  the consumer accepts the record.
REQ-010 Port: out_index  output  64  global cover index = COVER_INDEX + bit position.
REQ-011 Port: hit_count  output  $clog2(W+1)  number of distinct points accepted by the consumer.
REQ-012 Port: all_covered  output  1  high when hit_count equals W.

Function
REQ-013 The block SHALL report each point at most once per session: the first hit is reported, and later hits on the same point are dropped.
REQ-014 Pending bitmap P, reported bitmap R: each cycle with enable high, the bits of valid & ~P & ~R SHALL be set in P at the next edge.
REQ-015 The output register SHALL be empty when out_valid is low or when out_valid && out_ready.
REQ-016 When the output register is empty and P is nonzero, the block SHALL load the lowest set bit b of P into the output register.
REQ-017 On that load, the block SHALL clear P[b], set R[b], drive out_valid high and drive out_index = COVER_INDEX + b, all at the next edge.
REQ-018 The output is a back-to-back stage: consumption and load of the next pending bit SHALL occur in the same cycle, giving one record per cycle while out_ready is held high.
REQ-019 While out_valid && !out_ready, out_valid and out_index SHALL remain stable, and P SHALL continue to accumulate hits.
REQ-020 Latency: a hit sampled at edge N with the pipeline idle SHALL show out_valid at edge N+2.
REQ-021 hit_count SHALL increment by one on each out_valid && out_ready cycle and SHALL saturate at W.
REQ-022 A hit on the bit currently held in the output register, or already in R, SHALL be ignored.
REQ-023 Multiple simultaneous hits SHALL all be captured in P and SHALL be reported in ascending bit order.
REQ-024 out_index SHALL be computed in 64-bit unsigned arithmetic and SHALL not be truncated.
REQ-025 clear SHALL zero P, R, hit_count and out_valid at the next edge.
REQ-026 clear SHALL win over hits and over a handshake in the same cycle; such hits are discarded.
REQ-027 The block SHALL stay silent with P zero: out_valid low and no state change other than clear/reset.

Reset
REQ-028 On reset high at a clock edge, the block SHALL set P=0, R=0, out_valid=0, out_index=0, hit_count=0 and all_covered=0.
REQ-029 Reset SHALL take priority over clear, enable and out_ready.
REQ-030 Reset mid-transfer SHALL drop the presented record without completing it.

Structure
REQ-031 Package cover_pkg SHALL hold COVER_IDX_W=64 and the function that computes the count width.
REQ-032 Sub-module cover_prio_enc SHALL implement the W-bit lowest-set-bit encoder, with outputs found and idx.
REQ-033 The module SHALL have no DPI calls and SHALL be synthesizable.

Verification
REQ-034 Scenario: COVER_INDEX=100, out_ready=1, valid=0x000005 for one cycle -> out_index 100, then 102, on consecutive cycles; hit_count ends at 2.
REQ-035 Scenario: valid bit 3 pulsed 5 times over 20 cycles -> exactly one record with index COVER_INDEX+3; hit_count=1.
REQ-036 Scenario: out_ready=0 for 10 cycles after a record appears, valid=0x1FFFFF -> out_index stable for those cycles; then 21 records in ascending order; all_covered=1.
REQ-037 Scenario: clear asserted together with valid bit 7 and an active handshake -> next cycle hit_count=0, out_valid=0, and no record for bit 7.
REQ-038 Scenario: enable=0 with valid=0x1FFFFF -> no records; then enable=1 with valid bit 0 -> one record at COVER_INDEX+0.
REQ-039 Scenario: reset asserted while out_valid=1 and out_ready=0 -> next cycle all outputs zero, and a re-hit of the same bit is reported again.

Source files
------------

// File: rtl/cover_pkg.sv
// Shared constants and width helpers for the toggle
// coverage scheduler.
package cover_pkg;

  localparam int COVER_IDX_W = 64;

  function automatic int cnt_w(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder over a W-bit
// request vector.
module cover_prio_enc
  import cover_pkg::*;
#(
  parameter int W = 21
) (
  input  logic [W-1:0]         req,
  output logic                 found,
  output logic [idx_w(W)-1:0]  idx
);

  localparam int IW = idx_w(W);

  // scan high to low so the lowest set bit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// Toggle coverage scheduler: reports each hit point once
// per session through a back-to-back valid/ready stage.
module cover_toggle_sched
  import cover_pkg::*;
#(
  parameter int                     W           = 21,
  parameter logic [COVER_IDX_W-1:0] COVER_INDEX = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [W-1:0]            valid,
  input  logic                    enable,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COVER_IDX_W-1:0]  out_index,
  output logic [cnt_w(W)-1:0]     hit_count,
  output logic                    all_covered
);

  localparam int IW = idx_w(W);
  localparam int CW = cnt_w(W);

  logic [W-1:0]  pend;
  logic [W-1:0]  done;
  logic [W-1:0]  hits;
  logic [W-1:0]  pick;
  logic [W-1:0]  pend_nxt;
  logic [W-1:0]  done_nxt;
  logic          found;
  logic [IW-1:0] idx;
  logic          take;
  logic          load;

  cover_prio_enc #(.W(W)) u_enc (
    .req   (pend),
    .found (found),
    .idx   (idx)
  );

  // new hits, handshake and pending/reported updates
  always_comb begin
    hits     = valid & ~done & {W{enable}};
    take     = out_valid & out_ready;
    load     = (~out_valid | out_ready) & found;
    pick     = '0;
    if (load) pick = W'(1) << idx;
    pend_nxt = (pend | hits) & ~pick;
    done_nxt = done | pick;
  end

  assign all_covered = (hit_count == CW'(W));

  // session state, output register and hit counter
  always_ff @(posedge clock) begin
    if (reset) begin
      pend      <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      hit_count <= '0;
    end else if (clear) begin
      pend      <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      hit_count <= '0;
    end else begin
      pend <= pend_nxt;
      done <= done_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_index <= COVER_INDEX +
          {{(COVER_IDX_W-IW){1'b0}}, idx};
      end else if (take) begin
        out_valid <= 1'b0;
      end
      if (take && hit_count != CW'(W))
        hit_count <= hit_count + 1'b1;
    end
  end

endmodule
